// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer between execute-stage resolution and fetch.
// Optional perf counters are built only when BR_PERF_CNT_EN is defined.
module branch_redirect_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            if_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if,
  output logic            kill_ex,
  output logic            misalign_exc,
  output logic [31:0]     perf_taken_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  // Handshake: the redirect is accepted at the rising edge where
  // redirect_valid && if_ready; redirect_pc holds steady until then.

  state_t          state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            kill_c, res_c;
  logic            rv_c, flush_c, mis_c;
  logic [XLEN-1:0] pc_c;

  assign kill_c = (state_q != S_IDLE);
  assign res_c  = ex_valid & ~ex_stall & ex_br_taken & ~kill_c;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    rv_c      = 1'b0;
    pc_c      = ex_target;
    flush_c   = 1'b0;
    mis_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (res_c) begin
          if (ex_target[1:0] == 2'b00) begin
            rv_c    = 1'b1;
            flush_c = 1'b1;
            if (if_ready) begin
              state_d = S_BUBBLE;
            end else begin
              pend_pc_d = ex_target;
              state_d   = S_WAIT;
            end
          end else begin
            mis_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        rv_c    = 1'b1;
        pc_c    = pend_pc_q;
        flush_c = 1'b1;
        if (if_ready) state_d = S_BUBBLE;
      end
      S_BUBBLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Outputs are forced low while reset is held, including the combinational ones.
  assign redirect_valid = rst_n & rv_c;
  assign redirect_pc    = rst_n ? pc_c : '0;
  assign flush_if       = rst_n & flush_c;
  assign kill_ex        = rst_n & kill_c;
  assign misalign_exc   = rst_n & mis_c;
  assign dbg_state      = state_q;

`ifdef BR_PERF_CNT_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q + ((rv_c & if_ready) ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flush_c ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_taken_cnt = taken_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_taken_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
